// File: rtl/glitch_cmd_pkg.sv
// Protocol constants shared by the glitcher command parser and initiator:
// opcode bytes, parameter codes, response bytes and request status codes.
package glitch_cmd_pkg;

  localparam logic [7:0] CMD_PING   = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;
  localparam logic [7:0] CMD_ARM    = 8'h04;
  localparam logic [7:0] CMD_DISARM = 8'h05;

  localparam logic [3:0] PARAM_CLKEDGES   = 4'd1;
  localparam logic [3:0] PARAM_IOEDGES    = 4'd2;
  localparam logic [3:0] PARAM_NSEDGES    = 4'd3;
  localparam logic [3:0] PARAM_PULSEWIDTH = 4'd4;

  localparam logic [7:0] RESP_ACK    = 8'hAA;
  localparam logic [7:0] RESP_NACK   = 8'hFF;
  localparam logic [7:0] RESP_DISARM = 8'h21;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NACK    = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_ILLEGAL = 2'd3
  } rsp_status_e;

  // Request opcodes share their numeric value with the wire opcode byte.
  function automatic logic req_legal(input logic [2:0] op, input logic [3:0] param);
    logic rw;
    rw = (op == CMD_READ[2:0]) || (op == CMD_WRITE[2:0]);
    if (op == 3'd0 || op > CMD_DISARM[2:0]) return 1'b0;
    if (rw && (param == 4'd0 || param > PARAM_PULSEWIDTH)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/cmd_initiator_if.sv
// Request/response, UART transmit and UART receive signals of the command initiator.
interface cmd_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [3:0]  req_param;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_rdata;
  logic        tx_strobe;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_strobe;
  logic [7:0]  rx_byte;

  modport master (
    output req_valid, req_op, req_param, req_wdata, tx_done, rx_strobe, rx_byte,
    input  req_ready, rsp_valid, rsp_status, rsp_rdata, tx_strobe, tx_byte
  );

  modport slave (
    input  req_valid, req_op, req_param, req_wdata, tx_done, rx_strobe, rx_byte,
    output req_ready, rsp_valid, rsp_status, rsp_rdata, tx_strobe, tx_byte
  );
endinterface

// File: rtl/cmd_timeout.sv
// Saturating wait counter: clr has priority over en; tc is high while the count equals LIMIT.
module cmd_timeout #(
  parameter int unsigned LIMIT = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == W'(LIMIT));
endmodule

// File: rtl/cmd_initiator.sv
// Turns one word-level request into the glitcher command byte stream and returns one status.
// Strobe one cycle after acceptance or tx_done; rsp_valid one cycle after the final response.
module cmd_initiator
  import glitch_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input logic clk,
  input logic rst_n,
  cmd_initiator_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RSP, DONE} state_e;

  state_e      state;
  logic [2:0]  op_q;
  logic [3:0]  param_q;
  logic [31:0] wdata_q;
  logic        illegal_q;
  logic [1:0]  byte_idx;
  logic [1:0]  word_idx;
  logic [31:0] rdata_q;
  rsp_status_e status_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  rsp_status_e rsp_status_q;
  logic [31:0] rsp_rdata_q;
  logic        tx_strobe_q;
  logic [7:0]  tx_byte_q;

  logic       rw_op, is_read, last_byte, last_word, rsp_take, rsp_bad, tc, tmo_clr, tmo_en;
  logic [7:0] exp_rsp, byte_sel;

  assign is_read   = (op_q == CMD_READ[2:0]);
  assign rw_op     = is_read || (op_q == CMD_WRITE[2:0]);
  assign last_byte = !rw_op || (byte_idx == 2'd2);
  assign last_word = !rw_op || (word_idx == 2'd3);
  assign exp_rsp   = (op_q == CMD_DISARM[2:0]) ? RESP_DISARM : RESP_ACK;
  assign rsp_bad   = (bus.rx_byte == RESP_NACK) || (!is_read && bus.rx_byte != exp_rsp);

  // A response coinciding with the final tx_done still belongs to this transaction.
  assign rsp_take = bus.rx_strobe &&
                    ((state == WAIT_RSP) || (state == WAIT_TX && bus.tx_done && last_byte));

  always_comb begin
    byte_sel = 8'h00;
    case (byte_idx)
      2'd0:    byte_sel = {5'd0, op_q};
      2'd1:    byte_sel = is_read ? {4'h0, param_q} : {param_q, 2'b00, word_idx};
      default: byte_sel = is_read ? {6'd0, word_idx} : wdata_q[{word_idx, 3'b000} +: 8];
    endcase
  end

  assign tmo_clr = (state == SEND) || (state == WAIT_TX && bus.tx_done);
  assign tmo_en  = (state == WAIT_TX) || (state == WAIT_RSP);

  cmd_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (tmo_en),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      param_q      <= '0;
      wdata_q      <= '0;
      illegal_q    <= 1'b0;
      byte_idx     <= '0;
      word_idx     <= '0;
      rdata_q      <= '0;
      status_q     <= ST_OK;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= ST_OK;
      rsp_rdata_q  <= '0;
      tx_strobe_q  <= 1'b0;
      tx_byte_q    <= '0;
    end else begin
      tx_strobe_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          op_q        <= bus.req_op;
          param_q     <= bus.req_param;
          wdata_q     <= bus.req_wdata;
          illegal_q   <= !req_legal(bus.req_op, bus.req_param);
          byte_idx    <= '0;
          word_idx    <= '0;
          rdata_q     <= '0;
          req_ready_q <= 1'b0;
          state       <= SEND;
        end
        SEND: if (illegal_q) begin
          status_q <= ST_ILLEGAL;
          state    <= DONE;
        end else begin
          tx_strobe_q <= 1'b1;
          tx_byte_q   <= byte_sel;
          state       <= WAIT_TX;
        end
        WAIT_TX: if (bus.tx_done) begin
          if (!last_byte) begin
            byte_idx <= byte_idx + 1'b1;
            state    <= SEND;
          end else begin
            state <= WAIT_RSP;
          end
        end else if (tc) begin
          status_q <= ST_TIMEOUT;
          state    <= DONE;
        end
        WAIT_RSP: if (tc) begin
          status_q <= ST_TIMEOUT;
          state    <= DONE;
        end
        DONE: begin
          rsp_valid_q  <= 1'b1;
          rsp_status_q <= status_q;
          rsp_rdata_q  <= rdata_q;
          req_ready_q  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Response handling overrides the wait-state transitions above.
      if (rsp_take) begin
        if (is_read && !rsp_bad) rdata_q[{word_idx, 3'b000} +: 8] <= bus.rx_byte;
        if (rsp_bad) begin
          status_q <= ST_NACK;
          state    <= DONE;
        end else if (last_word) begin
          status_q <= ST_OK;
          state    <= DONE;
        end else begin
          word_idx <= word_idx + 1'b1;
          byte_idx <= '0;
          state    <= SEND;
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.tx_strobe  = tx_strobe_q;
  assign bus.tx_byte    = tx_byte_q;
endmodule

// File: tb/tb_cmd_initiator.sv
// Directed table-driven bench for cmd_initiator with a cycle-stepped UART transmitter/responder model.
module tb_cmd_initiator;
  import glitch_cmd_pkg::*;

  localparam int TMO    = 100;
  localparam int BUDGET = 400;
  localparam int NVEC   = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_initiator_if bus();

  cmd_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  param;
    logic [31:0] wdata;
    logic [31:0] rsp;       // response byte k in bits [8k+:8]
    int          n_give;    // number of responses the responder will send
    int          dly;       // cycles from final tx_done to response
    int          exp_n;
    logic [95:0] exp_bytes; // transmitted bytes, last byte in the low bits
    logic [1:0]  exp_st;
    logic [31:0] exp_rd;
    int          exp_cyc;   // acceptance-to-rsp_valid cycles, -1 when not checked
  } vec_t;

  vec_t vec[NVEC];

  int checks = 0;
  int failures = 0;

  logic [95:0] txlog;
  int          nbytes, rsp_cyc, last_done;
  bit          got;
  logic [1:0]  st;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v);
    int txc, rsc, bidx, ridx, per;
    logic [31:0] rw;
    per = (v.op == 3'd2 || v.op == 3'd3) ? 3 : 1;
    rw = v.rsp;
    txlog = '0; nbytes = 0; got = 0; rsp_cyc = -1; last_done = -1;
    st = '0; rd = '0;
    txc = -1; rsc = -1; bidx = 0; ridx = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = v.op; bus.req_param = v.param; bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int cyc = 0; cyc < BUDGET && !got; cyc++) begin
      bus.tx_done = 1'b0;
      bus.rx_strobe = 1'b0;
      if (bus.tx_strobe) begin
        txlog = {txlog[87:0], bus.tx_byte};
        nbytes++;
        txc = 2;
      end
      if (bus.rsp_valid) begin
        got = 1; rsp_cyc = cyc; st = bus.rsp_status; rd = bus.rsp_rdata;
      end
      if (txc == 0) begin
        bus.tx_done = 1'b1;
        txc = -1;
        bidx++;
        if (bidx == per) begin
          bidx = 0; rsc = v.dly; last_done = cyc;
        end
      end else if (txc > 0) begin
        txc--;
      end
      if (rsc == 0) begin
        rsc = -1;
        if (ridx < v.n_give) begin
          bus.rx_strobe = 1'b1;
          bus.rx_byte = rw[8*ridx +: 8];
        end
        ridx++;
      end else if (rsc > 0) begin
        rsc--;
      end
      @(negedge clk);
    end
    bus.tx_done = 1'b0;
    bus.rx_strobe = 1'b0;
  endtask

  task automatic apply_vec(input int k);
    logic in_win;
    run_req(vec[k]);
    chk($sformatf("v%0d_completed", k), 128'(got), 128'(1));
    chk($sformatf("v%0d_nbytes", k), 128'(nbytes), 128'(vec[k].exp_n));
    chk($sformatf("v%0d_bytes", k), 128'(txlog), 128'(vec[k].exp_bytes));
    chk($sformatf("v%0d_status", k), 128'(st), 128'(vec[k].exp_st));
    chk($sformatf("v%0d_rdata", k), 128'(rd), 128'(vec[k].exp_rd));
    if (vec[k].exp_cyc >= 0)
      chk($sformatf("v%0d_latency", k), 128'(rsp_cyc), 128'(vec[k].exp_cyc));
    if (vec[k].exp_st == ST_TIMEOUT) begin
      in_win = (rsp_cyc - last_done >= TMO + 1) && (rsp_cyc - last_done <= TMO + 3);
      chk($sformatf("v%0d_timeout_window", k), 128'(in_win), 128'(1));
    end
    chk($sformatf("v%0d_pulse_ready_hold", k),
        128'({bus.rsp_valid, bus.req_ready, bus.rsp_status}), 128'({1'b0, 1'b1, vec[k].exp_st}));
  endtask

  initial begin
    logic quiet;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_param = '0; bus.req_wdata = '0;
    bus.tx_done = 1'b0; bus.rx_strobe = 1'b0; bus.rx_byte = '0;

    vec[0]  = '{3'd1, 4'd0, 32'h0, 32'h000000AA, 1, 10, 1, 96'h01, 2'd0, 32'h0, -1};
    vec[1]  = '{3'd3, 4'd2, 32'hDEADBEEF, 32'hAAAAAAAA, 4, 3, 12,
                96'h0320EF_0321BE_0322AD_0323DE, 2'd0, 32'h0, -1};
    vec[2]  = '{3'd2, 4'd4, 32'h0, 32'h12345678, 4, 0, 12,
                96'h020400_020401_020402_020403, 2'd0, 32'h12345678, -1};
    vec[3]  = '{3'd3, 4'd1, 32'h11223344, 32'hAAAAFFAA, 4, 2, 6, 96'h031044_031133, 2'd1, 32'h0, -1};
    vec[4]  = '{3'd5, 4'd0, 32'h0, 32'h000000AA, 1, 4, 1, 96'h05, 2'd1, 32'h0, -1};
    vec[5]  = '{3'd5, 4'd0, 32'h0, 32'h00000021, 1, 1, 1, 96'h05, 2'd0, 32'h0, -1};
    vec[6]  = '{3'd4, 4'd0, 32'h0, 32'h000000AA, 1, 0, 1, 96'h04, 2'd0, 32'h0, -1};
    vec[7]  = '{3'd7, 4'd1, 32'h0, 32'h0, 0, 0, 0, 96'h0, 2'd3, 32'h0, 2};
    vec[8]  = '{3'd0, 4'd0, 32'h0, 32'h0, 0, 0, 0, 96'h0, 2'd3, 32'h0, 2};
    vec[9]  = '{3'd2, 4'd0, 32'h0, 32'h0, 0, 0, 0, 96'h0, 2'd3, 32'h0, 2};
    vec[10] = '{3'd3, 4'd5, 32'h0, 32'h0, 0, 0, 0, 96'h0, 2'd3, 32'h0, 2};
    vec[11] = '{3'd2, 4'd3, 32'h0, 32'h000000FF, 1, 2, 3, 96'h020300, 2'd1, 32'h0, -1};
    vec[12] = '{3'd2, 4'd1, 32'h0, 32'h0000BBAA, 2, 5, 9,
                96'h020100_020101_020102, 2'd2, 32'h0000BBAA, -1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        128'({bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata, bus.tx_strobe, bus.tx_byte}),
        128'({1'b1, 1'b0, 2'd0, 32'h0, 1'b0, 8'h00}));

    // Stray responses while idle must be dropped without side effects.
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.rx_strobe = i[0];
      bus.rx_byte = 8'hAA;
      @(negedge clk);
      if (bus.tx_strobe || bus.rsp_valid || !bus.req_ready) quiet = 1'b0;
    end
    bus.rx_strobe = 1'b0;
    chk("stray_rx_idle_quiet", 128'(quiet), 128'(1));

    for (int k = 0; k < NVEC; k++) apply_vec(k);

    // Reset in the middle of a READ, while the first byte is being strobed.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd2; bus.req_param = 4'd1; bus.req_wdata = '0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_strobe_before", 128'({bus.tx_strobe, bus.tx_byte}), 128'({1'b1, 8'h02}));
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_strobe_async", 128'(bus.tx_strobe), 128'(0));
    chk("midrst_outputs",
        128'({bus.req_ready, bus.rsp_valid, bus.rsp_status, bus.rsp_rdata, bus.tx_byte}),
        128'({1'b1, 1'b0, 2'd0, 32'h0, 8'h00}));
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.tx_strobe) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.tx_strobe) quiet = 1'b0;
    end
    chk("midrst_no_rsp", 128'(quiet), 128'(1));
    apply_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
